// File: rtl/trig_arbiter_if.sv
// ----------------------------------------------------------------------------
// trig_arbiter_if
// Bundles the request, control and readback signals of trig_arbiter.
//   slave  : arbiter side (consumes requests/control, drives trigger/status)
//   master : requester/bus side (drives requests/control, reads status)
// Signals:
//   io_req, io_src_en        per-source request and enable
//   io_allEnd                logic-end pulse from the layer logic
//   io_holdoff, io_timeout   programmed gap after end / max wait for end
//   io_abort, io_clr_cnt     force idle / clear counters and timeout flag
//   io_mainTrigger           one-cycle trigger to the logic
//   io_grant_idx, io_pending last granted source, pending flags
//   io_busy, io_timeout_flag arbiter busy, sticky timeout indication
//   io_accept_cnt/drop_cnt   packed per-source counters, source 0 at LSBs
// ----------------------------------------------------------------------------
interface trig_arbiter_if #(
  parameter int N_SRC  = 4,
  parameter int CNT_W  = 16,
  parameter int HOLD_W = 24,
  parameter int TMO_W  = 32
);
  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0]       io_req;
  logic [N_SRC-1:0]       io_src_en;
  logic                   io_allEnd;
  logic [HOLD_W-1:0]      io_holdoff;
  logic [TMO_W-1:0]       io_timeout;
  logic                   io_abort;
  logic                   io_clr_cnt;
  logic                   io_mainTrigger;
  logic [IDX_W-1:0]       io_grant_idx;
  logic [N_SRC-1:0]       io_pending;
  logic                   io_busy;
  logic                   io_timeout_flag;
  logic [N_SRC*CNT_W-1:0] io_accept_cnt;
  logic [N_SRC*CNT_W-1:0] io_drop_cnt;

  modport slave (
    input  io_req, io_src_en, io_allEnd, io_holdoff, io_timeout, io_abort, io_clr_cnt,
    output io_mainTrigger, io_grant_idx, io_pending, io_busy, io_timeout_flag,
           io_accept_cnt, io_drop_cnt
  );

  modport master (
    output io_req, io_src_en, io_allEnd, io_holdoff, io_timeout, io_abort, io_clr_cnt,
    input  io_mainTrigger, io_grant_idx, io_pending, io_busy, io_timeout_flag,
           io_accept_cnt, io_drop_cnt
  );
endinterface

// File: rtl/trig_arbiter.sv
// ----------------------------------------------------------------------------
// trig_arbiter
// Shares the single main-trigger input of the sync-trigger logic between
// N_SRC requesters. Each source has a one-deep pending slot; pending sources
// are granted round-robin. A grant fires a one-cycle io_mainTrigger, then the
// arbiter waits for io_allEnd (or a timeout) and applies a hold-off gap before
// the next grant. Per-source accept/drop counters saturate at all-ones.
// Ports:
//   io_clk      clock
//   io_rst_ram  asynchronous active-high reset (all state to reset values)
//   bus         trig_arbiter_if.slave, see the interface for signal list
// ----------------------------------------------------------------------------
module trig_arbiter #(
  parameter int N_SRC  = 4,
  parameter int CNT_W  = 16,
  parameter int HOLD_W = 24,
  parameter int TMO_W  = 32
) (
  input  logic          io_clk,
  input  logic          io_rst_ram,
  trig_arbiter_if.slave bus
);
  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FIRE = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [TMO_W-1:0]  wait_q, wait_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              tflag_q, tflag_d;
  logic              trig_q, trig_d;
  logic [N_SRC-1:0]  pend_q, pend_d;
  logic [N_SRC-1:0]  eligible, fire_oh, drop_inc;
  logic [CNT_W-1:0]  acc_q  [N_SRC];
  logic [CNT_W-1:0]  drop_q [N_SRC];
  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic              tmo_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != {CNT_W{1'b1}})) return v + CNT_W'(1);
    return v;
  endfunction

  assign eligible = pend_q & bus.io_src_en;
  // One-hot of the source whose slot is consumed by this cycle's pulse.
  assign fire_oh  = (state_q == S_FIRE) ? (N_SRC'(1) << grant_q) : '0;
  assign tmo_hit  = (state_q == S_WAIT) && (bus.io_timeout != '0) && (wait_q == bus.io_timeout);

  // Round-robin: first eligible source searching upward from last grant + 1.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      if (!sel_found && eligible[(int'(last_q) + k) % N_SRC]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'((int'(last_q) + k) % N_SRC);
      end
    end
  end

  // Pending slots: a new request wins over the grant clearing the slot, so a
  // request coinciding with its own grant stays pending and is not a drop.
  always_comb begin
    pend_d   = pend_q;
    drop_inc = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (!bus.io_src_en[i]) begin
        pend_d[i] = 1'b0;
      end else if (bus.io_req[i]) begin
        pend_d[i]   = 1'b1;
        drop_inc[i] = pend_q[i] & ~fire_oh[i];
      end else if (fire_oh[i]) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wait_d  = wait_q;
    hold_d  = hold_q;
    tflag_d = tflag_q;
    if (bus.io_abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sel_found) begin
            grant_d = sel_idx;
            last_d  = sel_idx;
            state_d = S_FIRE;
          end
        end
        S_FIRE: begin
          // An io_allEnd during FIRE is not looked at.
          wait_d  = TMO_W'(1);
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (bus.io_allEnd || tmo_hit) begin
            if (tmo_hit) tflag_d = 1'b1;
            hold_d  = bus.io_holdoff;
            state_d = (bus.io_holdoff == '0) ? S_IDLE : S_HOLD;
          end else begin
            wait_d = wait_q + TMO_W'(1);
          end
        end
        default: begin
          if (hold_q <= HOLD_W'(1)) state_d = S_IDLE;
          else                      hold_d  = hold_q - HOLD_W'(1);
        end
      endcase
    end
    if (bus.io_clr_cnt) tflag_d = 1'b0;
  end

  // Pulse is registered so it is high exactly while the state is FIRE.
  assign trig_d = (state_d == S_FIRE);

  always_ff @(posedge io_clk or posedge io_rst_ram) begin
    if (io_rst_ram) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(N_SRC - 1);
      wait_q  <= '0;
      hold_q  <= '0;
      tflag_q <= 1'b0;
      trig_q  <= 1'b0;
      pend_q  <= '0;
      for (int i = 0; i < N_SRC; i++) begin
        acc_q[i]  <= '0;
        drop_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wait_q  <= wait_d;
      hold_q  <= hold_d;
      tflag_q <= tflag_d;
      trig_q  <= trig_d;
      pend_q  <= pend_d;
      for (int i = 0; i < N_SRC; i++) begin
        if (bus.io_clr_cnt) begin
          acc_q[i]  <= '0;
          drop_q[i] <= '0;
        end else begin
          acc_q[i]  <= sat_inc(acc_q[i], fire_oh[i]);
          drop_q[i] <= sat_inc(drop_q[i], drop_inc[i]);
        end
      end
    end
  end

  always_comb begin
    bus.io_accept_cnt = '0;
    bus.io_drop_cnt   = '0;
    for (int i = 0; i < N_SRC; i++) begin
      bus.io_accept_cnt[i*CNT_W +: CNT_W] = acc_q[i];
      bus.io_drop_cnt[i*CNT_W +: CNT_W]   = drop_q[i];
    end
  end

  assign bus.io_mainTrigger  = trig_q;
  assign bus.io_grant_idx    = grant_q;
  assign bus.io_pending      = pend_q;
  assign bus.io_busy         = (state_q != S_IDLE);
  assign bus.io_timeout_flag = tflag_q;

endmodule

// File: tb/tb_trig_arbiter.sv
// ----------------------------------------------------------------------------
// tb_trig_arbiter
// Directed bench for trig_arbiter: round-robin order, pending/drop handling,
// hold-off, timeout, abort, asynchronous reset and counter saturation.
// ----------------------------------------------------------------------------
module tb_trig_arbiter;
  logic io_clk;
  logic io_rst_ram;
  int   n_chk;
  int   n_fail;
  int   n;

  trig_arbiter_if bus ();

  trig_arbiter dut (
    .io_clk     (io_clk),
    .io_rst_ram (io_rst_ram),
    .bus        (bus)
  );

  initial io_clk = 1'b0;
  always #5 io_clk = ~io_clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] cnt_of(input logic [63:0] vec, input int i);
    return vec[i*16 +: 16];
  endfunction

  task automatic tick();
    @(posedge io_clk);
    #1;
  endtask

  // Waits (bounded) until the trigger pulse is visible; returns ticks spent.
  task automatic wait_fire(input string tag, output int cycles);
    cycles = 0;
    while (!bus.io_mainTrigger && cycles < 300) begin
      tick();
      cycles++;
    end
    check_val(tag, 64'(bus.io_mainTrigger), 64'd1);
  endtask

  task automatic end_pulse();
    bus.io_allEnd = 1'b1;
    tick();
    bus.io_allEnd = 1'b0;
  endtask

  task automatic pulse_req(input logic [3:0] r);
    bus.io_req = r;
    tick();
    bus.io_req = 4'b0000;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    io_rst_ram     = 1'b1;
    bus.io_req     = '0;
    bus.io_src_en  = 4'hF;
    bus.io_allEnd  = 1'b0;
    bus.io_holdoff = '0;
    bus.io_timeout = '0;
    bus.io_abort   = 1'b0;
    bus.io_clr_cnt = 1'b0;
    tick();
    tick();
    check_val("rst_trig",    64'(bus.io_mainTrigger), 64'd0);
    check_val("rst_busy",    64'(bus.io_busy), 64'd0);
    check_val("rst_grant",   64'(bus.io_grant_idx), 64'd0);
    check_val("rst_pending", 64'(bus.io_pending), 64'd0);
    check_val("rst_tflag",   64'(bus.io_timeout_flag), 64'd0);
    check_val("rst_acc",     bus.io_accept_cnt, 64'd0);
    check_val("rst_drop",    bus.io_drop_cnt, 64'd0);
    io_rst_ram = 1'b0;
    tick();

    // Single request on source 2
    pulse_req(4'b0100);
    check_val("t1_pending", 64'(bus.io_pending), 64'b0100);
    check_val("t1_no_trig_yet", 64'(bus.io_mainTrigger), 64'd0);
    tick();
    check_val("t1_trig", 64'(bus.io_mainTrigger), 64'd1);
    check_val("t1_grant", 64'(bus.io_grant_idx), 64'd2);
    tick();
    check_val("t1_trig_one_cycle", 64'(bus.io_mainTrigger), 64'd0);
    check_val("t1_acc2", 64'(cnt_of(bus.io_accept_cnt, 2)), 64'd1);
    check_val("t1_pending_clr", 64'(bus.io_pending), 64'd0);
    check_val("t1_busy_wait", 64'(bus.io_busy), 64'd1);
    repeat (6) tick();
    end_pulse();
    check_val("t1_busy_low", 64'(bus.io_busy), 64'd0);

    // All four request at once, fresh reset so source 0 is first
    #3 io_rst_ram = 1'b1;
    #2 io_rst_ram = 1'b0;
    tick();
    pulse_req(4'b1111);
    check_val("t2_pending", 64'(bus.io_pending), 64'hF);
    for (int g = 0; g < 4; g++) begin
      wait_fire("t2_fire", n);
      check_val("t2_grant", 64'(bus.io_grant_idx), 64'(g));
      tick();
      if (g == 3) bus.io_req = 4'b0001;
      tick();
      bus.io_req = 4'b0000;
      repeat (3) tick();
      end_pulse();
    end
    for (int i = 0; i < 4; i++)
      check_val("t2_acc", 64'(cnt_of(bus.io_accept_cnt, i)), 64'd1);
    check_val("t2_drop", bus.io_drop_cnt, 64'd0);
    wait_fire("t2_wrap_fire", n);
    check_val("t2_wrap_grant", 64'(bus.io_grant_idx), 64'd0);
    tick();
    end_pulse();

    // Drops while WAIT is blocked; allEnd during FIRE ignored
    pulse_req(4'b1000);
    wait_fire("t3_fire", n);
    check_val("t3_grant3", 64'(bus.io_grant_idx), 64'd3);
    tick();
    bus.io_req = 4'b0010;
    repeat (3) tick();
    bus.io_req = 4'b0000;
    check_val("t3_pending1", 64'(bus.io_pending), 64'b0010);
    check_val("t3_drop1", 64'(cnt_of(bus.io_drop_cnt, 1)), 64'd2);
    repeat (4) tick();
    check_val("t3_blocked_trig", 64'(bus.io_mainTrigger), 64'd0);
    check_val("t3_blocked_busy", 64'(bus.io_busy), 64'd1);
    end_pulse();
    wait_fire("t3_fire2", n);
    check_val("t3_grant1", 64'(bus.io_grant_idx), 64'd1);
    end_pulse();
    check_val("t3_end_in_fire_ignored", 64'(bus.io_busy), 64'd1);
    check_val("t3_acc1", 64'(cnt_of(bus.io_accept_cnt, 1)), 64'd2);
    end_pulse();
    check_val("t3_idle", 64'(bus.io_busy), 64'd0);

    // Hold-off of 100, changed mid-hold
    bus.io_holdoff = 24'd100;
    pulse_req(4'b0100);
    wait_fire("t4_fire", n);
    tick();
    pulse_req(4'b0001);
    end_pulse();
    check_val("t4_in_hold", 64'(bus.io_busy), 64'd1);
    bus.io_holdoff = 24'd5;
    wait_fire("t4_fire2", n);
    check_val("t4_gap", 64'(n), 64'd101);
    check_val("t4_grant0", 64'(bus.io_grant_idx), 64'd0);
    bus.io_holdoff = 24'd0;
    tick();
    end_pulse();
    check_val("t4_idle", 64'(bus.io_busy), 64'd0);

    // Timeout of 50 with no allEnd, then counter clear
    bus.io_timeout = 32'd50;
    pulse_req(4'b1000);
    wait_fire("t5_fire", n);
    repeat (49) tick();
    check_val("t5_flag_early", 64'(bus.io_timeout_flag), 64'd0);
    repeat (2) tick();
    check_val("t5_flag_set", 64'(bus.io_timeout_flag), 64'd1);
    check_val("t5_idle", 64'(bus.io_busy), 64'd0);
    bus.io_clr_cnt = 1'b1;
    tick();
    bus.io_clr_cnt = 1'b0;
    check_val("t5_flag_clr", 64'(bus.io_timeout_flag), 64'd0);
    check_val("t5_acc_clr", bus.io_accept_cnt, 64'd0);
    check_val("t5_drop_clr", bus.io_drop_cnt, 64'd0);
    bus.io_timeout = 32'd0;

    // Abort during WAIT
    pulse_req(4'b0100);
    wait_fire("t5_abort_fire", n);
    tick();
    bus.io_abort = 1'b1;
    tick();
    bus.io_abort = 1'b0;
    check_val("t5_abort_idle", 64'(bus.io_busy), 64'd0);
    check_val("t5_abort_acc", 64'(cnt_of(bus.io_accept_cnt, 2)), 64'd1);

    // Asynchronous reset during WAIT with three pending
    pulse_req(4'b0010);
    wait_fire("t6_fire", n);
    tick();
    pulse_req(4'b1101);
    check_val("t6_pending", 64'(bus.io_pending), 64'b1101);
    #3 io_rst_ram = 1'b1;
    #1;
    check_val("t6_rst_busy", 64'(bus.io_busy), 64'd0);
    check_val("t6_rst_pending", 64'(bus.io_pending), 64'd0);
    check_val("t6_rst_grant", 64'(bus.io_grant_idx), 64'd0);
    check_val("t6_rst_acc", bus.io_accept_cnt, 64'd0);
    #1 io_rst_ram = 1'b0;
    tick();
    pulse_req(4'b1101);
    wait_fire("t6_fire2", n);
    check_val("t6_first_grant", 64'(bus.io_grant_idx), 64'd0);
    #3 io_rst_ram = 1'b1;
    #1;
    check_val("t6_trig_cut", 64'(bus.io_mainTrigger), 64'd0);
    #1 io_rst_ram = 1'b0;
    tick();

    // Drop counter saturation, then clear beats a same-cycle drop
    pulse_req(4'b0010);
    wait_fire("t6_sat_fire", n);
    tick();
    bus.io_req = 4'b0001;
    repeat (65540) tick();
    check_val("t6_drop_sat", 64'(cnt_of(bus.io_drop_cnt, 0)), 64'hFFFF);
    tick();
    check_val("t6_drop_hold", 64'(cnt_of(bus.io_drop_cnt, 0)), 64'hFFFF);
    bus.io_clr_cnt = 1'b1;
    tick();
    bus.io_clr_cnt = 1'b0;
    bus.io_req = 4'b0000;
    check_val("t6_clr_prio", 64'(cnt_of(bus.io_drop_cnt, 0)), 64'd0);
    end_pulse();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
